tetris_input_sched: RTL and testbench

//   Converts the PS/2 code stream into Tetris command tokens for the game FSM.

---
 rtl/tetris_input_sched_if.sv | 21 ++
 rtl/tetris_input_sched.sv | 155 +++++++++++++++
 tb/tb_tetris_input_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tetris_input_sched_if.sv
// Handshake bundle between the PS/2 driver, the input scheduler and the game FSM.
interface tetris_input_sched_if;
   logic       valid;
   logic       makeBreak;
   logic [7:0] outCode;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [4:0] held;
   logic       dropped;

   modport master (
      output valid, makeBreak, outCode, cmd_ready,
      input  cmd_valid, cmd, held, dropped
   );

   modport slave (
      input  valid, makeBreak, outCode, cmd_ready,
      output cmd_valid, cmd, held, dropped
   );
endinterface

// File: rtl/tetris_input_sched.sv
// Turns PS/2 make/break codes into prioritised Tetris command tokens for the game FSM.
// Define TETRIS_KEY_REPEAT_EN to add DAS/ARR auto-repeat on LEFT, RIGHT and SOFT.
module tetris_input_sched #(
   parameter int unsigned DAS_DELAY  = 8000000,
   parameter int unsigned ARR_PERIOD = 2500000,
   parameter logic [7:0]  KC_LEFT    = 8'h6B,
   parameter logic [7:0]  KC_RIGHT   = 8'h74,
   parameter logic [7:0]  KC_ROT     = 8'h75,
   parameter logic [7:0]  KC_SOFT    = 8'h72,
   parameter logic [7:0]  KC_HARD    = 8'h29
) (
   input  logic                  clk,
   input  logic                  reset,
   tetris_input_sched_if.slave   bus
);

   localparam int unsigned NKEYS = 5;
   localparam logic [7:0] KEY_CODES [NKEYS] = '{KC_LEFT, KC_RIGHT, KC_ROT, KC_SOFT, KC_HARD};

   typedef enum logic {KEY_UNPRESSED, KEY_HELD} key_state_e;

   key_state_e       key_q [NKEYS];
   key_state_e       key_d [NKEYS];
   logic [NKEYS-1:0] pending_q, pending_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [2:0]       cmd_q, cmd_d;
   logic             dropped_q, dropped_d;

   logic [NKEYS-1:0] make_hit;
   logic [NKEYS-1:0] break_hit;
   logic [NKEYS-1:0] rpt_fire;
   logic [NKEYS-1:0] events;
   logic [NKEYS-1:0] clear_mask;
   logic [NKEYS-1:0] held_bits;
   logic             load;
   logic             sel_any;
   logic [2:0]       sel_idx;

   // Only the UNPRESSED->HELD edge counts as a press; typematic resends and stray breaks fall through.
   always_comb begin
      make_hit  = '0;
      break_hit = '0;
      held_bits = '0;
      for (int k = 0; k < NKEYS; k++) begin
         key_d[k]     = key_q[k];
         held_bits[k] = (key_q[k] == KEY_HELD);
         if (bus.valid && (bus.outCode == KEY_CODES[k])) begin
            make_hit[k]  = bus.makeBreak  && (key_q[k] == KEY_UNPRESSED);
            break_hit[k] = !bus.makeBreak && (key_q[k] == KEY_HELD);
         end
         if (make_hit[k]) begin
            key_d[k] = KEY_HELD;
         end else if (break_hit[k]) begin
            key_d[k] = KEY_UNPRESSED;
         end
      end
   end

`ifdef TETRIS_KEY_REPEAT_EN
   localparam int unsigned CNT_MAX  = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
   localparam int          CW       = $clog2(CNT_MAX + 1);
   localparam logic [NKEYS-1:0] RPT_KEYS = 5'b01011;

   logic [CW-1:0] rpt_q [NKEYS];
   logic [CW-1:0] rpt_d [NKEYS];

   // A break on the same edge the counter expires wins, so a released key never repeats.
   always_comb begin
      rpt_fire = '0;
      for (int k = 0; k < NKEYS; k++) begin
         rpt_d[k] = rpt_q[k];
         if (!RPT_KEYS[k]) begin
            rpt_d[k] = '0;
         end else if (make_hit[k]) begin
            rpt_d[k] = CW'(DAS_DELAY - 1);
         end else if (break_hit[k] || (key_q[k] == KEY_UNPRESSED)) begin
            rpt_d[k] = '0;
         end else if (rpt_q[k] == '0) begin
            rpt_fire[k] = 1'b1;
            rpt_d[k]    = CW'(ARR_PERIOD - 1);
         end else begin
            rpt_d[k] = rpt_q[k] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NKEYS; k++) begin
         if (reset) begin
            rpt_q[k] <= '0;
         end else begin
            rpt_q[k] <= rpt_d[k];
         end
      end
   end
`else
   assign rpt_fire = '0;
`endif

   assign events = make_hit | rpt_fire;
   assign load   = !cmd_valid_q || bus.cmd_ready;

   // Lowest index wins, giving LEFT > RIGHT > ROT > SOFT > HARD.
   always_comb begin
      sel_any = 1'b0;
      sel_idx = '0;
      for (int k = NKEYS - 1; k >= 0; k--) begin
         if (pending_q[k]) begin
            sel_any = 1'b1;
            sel_idx = 3'(k);
         end
      end
   end

   always_comb begin
      clear_mask  = '0;
      cmd_valid_d = cmd_valid_q;
      cmd_d       = cmd_q;
      if (load) begin
         cmd_valid_d = sel_any;
         cmd_d       = sel_any ? (sel_idx + 3'd1) : 3'd0;
         if (sel_any) begin
            clear_mask[sel_idx] = 1'b1;
         end
      end
      pending_d = (pending_q & ~clear_mask) | events;
      dropped_d = |(events & pending_q & ~clear_mask);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NKEYS; k++) begin
            key_q[k] <= KEY_UNPRESSED;
         end
         pending_q   <= '0;
         cmd_valid_q <= 1'b0;
         cmd_q       <= '0;
         dropped_q   <= 1'b0;
      end else begin
         for (int k = 0; k < NKEYS; k++) begin
            key_q[k] <= key_d[k];
         end
         pending_q   <= pending_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_q       <= cmd_d;
         dropped_q   <= dropped_d;
      end
   end

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd       = cmd_q;
   assign bus.held      = held_bits;
   assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_tetris_input_sched.sv
// Scoreboard bench for tetris_input_sched: directed key sequences, monitor checks every transfer.
module tb_tetris_input_sched;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   tetris_input_sched_if bus ();

   tetris_input_sched #(
      .DAS_DELAY  (8),
      .ARR_PERIOD (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int drop_cnt = 0;
   int exp_q [$];
   int xfer_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every accepted token is popped against the expected queue.
   always @(negedge clk) begin
      int exp_cmd;
      if (!reset) begin
         if (bus.dropped) drop_cnt++;
         if (bus.cmd_valid && bus.cmd_ready) begin
            xfer_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_cmd: got cmd=%0d, required no transfer", bus.cmd);
            end else begin
               exp_cmd = exp_q.pop_front();
               if (int'(bus.cmd) != exp_cmd) begin
                  errors++;
                  $display("[TB] FAIL cmd_order: got cmd=%0d, required %0d", bus.cmd, exp_cmd);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic mb, input logic [7:0] code);
      bus.valid     = 1'b1;
      bus.makeBreak = mb;
      bus.outCode   = code;
      @(posedge clk);
      #1;
      bus.valid     = 1'b0;
      bus.makeBreak = 1'b0;
      bus.outCode   = 8'h00;
   endtask

   task automatic waitDrain(input string name, input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) idle(1);
      idle(4);
      checkOutput(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      reset         = 1'b1;
      bus.valid     = 1'b0;
      bus.makeBreak = 1'b0;
      bus.outCode   = 8'h00;
      bus.cmd_ready = 1'b0;
      idle(3);
      reset = 1'b0;
      checkOutput("reset_cmd_valid", int'(bus.cmd_valid), 0);
      checkOutput("reset_cmd", int'(bus.cmd), 0);
      checkOutput("reset_held", int'(bus.held), 0);
      checkOutput("reset_dropped", int'(bus.dropped), 0);

      $display("[TB] T1 single press");
      bus.cmd_ready = 1'b1;
      exp_q.push_back(1);
      applyStimulus(1'b1, 8'h6B);
      checkOutput("t1_latency_early", int'(bus.cmd_valid), 0);
      checkOutput("t1_held_left", int'(bus.held), 5'b00001);
      idle(1);
      checkOutput("t1_cmd_valid", int'(bus.cmd_valid), 1);
      checkOutput("t1_cmd", int'(bus.cmd), 1);
      idle(6);
      checkOutput("t1_still_held", int'(bus.held), 5'b00001);
      applyStimulus(1'b0, 8'h6B);
      checkOutput("t1_released", int'(bus.held), 0);
      waitDrain("t1_drain", 20);

      $display("[TB] T2 priority order");
      drop_cnt = 0;
      bus.cmd_ready = 1'b0;
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(5);
      applyStimulus(1'b1, 8'h6B);
      applyStimulus(1'b1, 8'h74);
      applyStimulus(1'b1, 8'h29);
      idle(3);
      checkOutput("t2_stalled_cmd", int'(bus.cmd), 1);
      bus.cmd_ready = 1'b1;
      waitDrain("t2_drain", 20);
      checkOutput("t2_no_drop", drop_cnt, 0);
      applyStimulus(1'b0, 8'h6B);
      applyStimulus(1'b0, 8'h74);
      applyStimulus(1'b0, 8'h29);
      checkOutput("t2_all_released", int'(bus.held), 0);

      $display("[TB] T3 typematic resend and stray break");
      drop_cnt = 0;
      exp_q.push_back(3);
      applyStimulus(1'b1, 8'h75);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h75);
      checkOutput("t3_held_rot", int'(bus.held), 5'b00100);
      applyStimulus(1'b0, 8'h75);
      applyStimulus(1'b0, 8'h75);
      applyStimulus(1'b0, 8'h72);
      applyStimulus(1'b1, 8'h12);
      waitDrain("t3_drain", 20);
      checkOutput("t3_no_drop", drop_cnt, 0);
      checkOutput("t3_held_none", int'(bus.held), 0);

      $display("[TB] T4 merge into pending");
      drop_cnt = 0;
      bus.cmd_ready = 1'b0;
      exp_q.push_back(1);
      exp_q.push_back(4);
      applyStimulus(1'b1, 8'h6B);
      idle(1);
      applyStimulus(1'b1, 8'h72);
      applyStimulus(1'b0, 8'h72);
      applyStimulus(1'b1, 8'h72);
      idle(2);
      checkOutput("t4_drop_once", drop_cnt, 1);
      bus.cmd_ready = 1'b1;
      waitDrain("t4_drain", 20);
      applyStimulus(1'b0, 8'h6B);
      applyStimulus(1'b0, 8'h72);
      checkOutput("t4_drop_total", drop_cnt, 1);

      $display("[TB] T5 held movement key");
      bus.cmd_ready = 1'b1;
      xfer_cyc.delete();
`ifdef TETRIS_KEY_REPEAT_EN
      for (int i = 0; i < 4; i++) exp_q.push_back(2);
`else
      exp_q.push_back(2);
`endif
      applyStimulus(1'b1, 8'h74);
      idle(15);
      applyStimulus(1'b0, 8'h74);
      waitDrain("t5_drain", 20);
      idle(10);
`ifdef TETRIS_KEY_REPEAT_EN
      checkOutput("t5_xfer_count", xfer_cyc.size(), 4);
      if (xfer_cyc.size() == 4) begin
         checkOutput("t5_das_gap", xfer_cyc[1] - xfer_cyc[0], 8);
         checkOutput("t5_arr_gap1", xfer_cyc[2] - xfer_cyc[1], 3);
         checkOutput("t5_arr_gap2", xfer_cyc[3] - xfer_cyc[2], 3);
      end
`else
      checkOutput("t5_xfer_count", xfer_cyc.size(), 1);
`endif

      $display("[TB] T6 reset mid-operation");
      bus.cmd_ready = 1'b0;
      applyStimulus(1'b1, 8'h6B);
      applyStimulus(1'b1, 8'h74);
      idle(1);
      checkOutput("t6_busy", int'(bus.cmd_valid), 1);
      reset = 1'b1;
      idle(1);
      checkOutput("t6_cmd_valid", int'(bus.cmd_valid), 0);
      checkOutput("t6_cmd", int'(bus.cmd), 0);
      checkOutput("t6_held", int'(bus.held), 0);
      checkOutput("t6_dropped", int'(bus.dropped), 0);
      reset = 1'b0;
      bus.cmd_ready = 1'b1;
      idle(10);
      checkOutput("t6_quiet", int'(bus.cmd_valid), 0);
      exp_q.push_back(5);
      applyStimulus(1'b1, 8'h29);
      waitDrain("t6_drain", 20);
      applyStimulus(1'b0, 8'h29);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
